// File: rtl/pkt_ingress_pkg.sv
// Shared types and constants for the packet ingress arbiter and its per-port FIFOs.
package pkt_ingress_pkg;

   localparam int unsigned PKT_WIDTH  = 134;
   localparam int unsigned DATA_WIDTH = PKT_WIDTH - 2;

   localparam logic [1:0] TAG_HEAD   = 2'b01;
   localparam logic [1:0] TAG_BODY   = 2'b00;
   localparam logic [1:0] TAG_TAIL   = 2'b10;
   localparam logic [1:0] TAG_SINGLE = 2'b11;

   // tag[1] set marks the last beat of a packet (tail or single).
   typedef struct packed {
      logic [1:0]            tag;
      logic [DATA_WIDTH-1:0] data;
   } pkt_beat_t;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } arb_state_e;

endpackage

// File: rtl/pkt_ingress_arbiter_fifo.sv
// Store-and-forward FWFT FIFO for one ingress port, with complete-packet count
// and overflow recovery (flush, then drop the rest of the oversize packet).
module pkt_port_fifo
   import pkt_ingress_pkg::*;
#(
   parameter int unsigned DEPTH = 64
) (
   input  logic      i_clk,
   input  logic      i_flush,
   input  logic      i_wr,
   input  pkt_beat_t i_din,
   input  logic      i_rd,
   output pkt_beat_t o_dout,
   output logic      o_empty,
   output logic      o_full,
   output logic      o_pkt_avail,
   output logic      o_drop_err
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   pkt_beat_t         r_mem [DEPTH];
   logic [AW-1:0]     r_wr_ptr;
   logic [AW-1:0]     r_rd_ptr;
   logic [CW-1:0]     r_count;
   logic [CW-1:0]     r_pkt_cnt;
   logic              r_discard;
   logic              r_drop_err;

   logic w_full;
   logic w_empty;
   logic w_ovf;
   logic w_push;
   logic w_pop;
   logic w_push_eop;
   logic w_pop_eop;

   assign w_full     = (r_count == CW'(DEPTH));
   assign w_empty    = (r_count == '0);
   // A full FIFO holding no complete packet can never drain: the packet is too long.
   assign w_ovf      = w_full && (r_pkt_cnt == '0) && !r_discard;
   assign w_push     = i_wr && !w_full && !r_discard;
   assign w_pop      = i_rd && !w_empty;
   assign w_push_eop = w_push && i_din.tag[1];
   assign w_pop_eop  = w_pop && o_dout.tag[1];

   assign o_dout      = r_mem[r_rd_ptr];
   assign o_empty     = w_empty;
   assign o_full      = w_full && !r_discard;
   assign o_pkt_avail = (r_pkt_cnt != '0);
   assign o_drop_err  = r_drop_err;

   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_din;
   end

   always_ff @(posedge i_clk) begin
      if (i_flush) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_pkt_cnt  <= '0;
         r_discard  <= 1'b0;
         r_drop_err <= 1'b0;
      end else if (w_ovf) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_discard  <= 1'b1;
         r_drop_err <= 1'b1;
      end else begin
         if (r_discard && i_wr && i_din.tag[1]) r_discard <= 1'b0;
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         r_count   <= r_count + CW'(w_push) - CW'(w_pop);
         r_pkt_cnt <= r_pkt_cnt + CW'(w_push_eop) - CW'(w_pop_eop);
      end
   end

endmodule

// File: rtl/pkt_ingress_arbiter.sv
// Packet-granular round-robin scheduler feeding the parser's single ingress stream
// from NUM_PORTS store-and-forward port FIFOs.
module pkt_ingress_arbiter
   import pkt_ingress_pkg::*;
#(
   parameter int unsigned NUM_PORTS    = 4,
   parameter int unsigned FIFO_DEPTH   = 64,
   parameter int unsigned PORT_ID_BASE = 0
) (
   input  logic                           i_clk,
   input  logic                           i_rst,
   input  logic [NUM_PORTS-1:0]           i_pkt_valid,
   input  logic [PKT_WIDTH*NUM_PORTS-1:0] i_pkt,
   output logic [NUM_PORTS-1:0]           o_pkt_ready,
   output logic                           o_pkt_valid,
   output logic [PKT_WIDTH-1:0]           o_pkt,
   output logic [7:0]                     o_inport,
   output logic [NUM_PORTS-1:0]           o_drop_err,
   output logic                           o_busy
);

   localparam int unsigned PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

   arb_state_e      r_state;
   logic [PW-1:0]   r_grant;
   logic [PW-1:0]   r_rr;

   arb_state_e      w_state_nxt;
   logic [PW-1:0]   w_grant_nxt;
   logic [PW-1:0]   w_rr_nxt;
   logic [7:0]      w_inport_nxt;
   logic            w_valid_nxt;
   pkt_beat_t       w_pkt_nxt;

   logic [NUM_PORTS-1:0] w_rd;
   logic [NUM_PORTS-1:0] w_empty;
   logic [NUM_PORTS-1:0] w_full;
   logic [NUM_PORTS-1:0] w_avail;
   pkt_beat_t            w_dout [NUM_PORTS];

   logic            w_found;
   logic [PW-1:0]   w_pick;
   logic [PW-1:0]   w_idx;

   for (genvar k = 0; k < NUM_PORTS; k++) begin : g_port
      pkt_port_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
         .i_clk       (i_clk),
         .i_flush     (i_rst),
         .i_wr        (i_pkt_valid[k]),
         .i_din       (i_pkt[PKT_WIDTH*k +: PKT_WIDTH]),
         .i_rd        (w_rd[k]),
         .o_dout      (w_dout[k]),
         .o_empty     (w_empty[k]),
         .o_full      (w_full[k]),
         .o_pkt_avail (w_avail[k]),
         .o_drop_err  (o_drop_err[k])
      );
   end

   assign o_pkt_ready = ~w_full;
   assign o_busy      = (r_state == SEND);

   // First port holding a complete packet, scanning upward from the last winner.
   always_comb begin
      w_found = 1'b0;
      w_pick  = '0;
      w_idx   = '0;
      for (int unsigned i = 1; i <= NUM_PORTS; i++) begin
         w_idx = PW'((32'(r_rr) + i) % NUM_PORTS);
         if (!w_found && w_avail[w_idx]) begin
            w_found = 1'b1;
            w_pick  = w_idx;
         end
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_grant_nxt  = r_grant;
      w_rr_nxt     = r_rr;
      w_inport_nxt = o_inport;
      w_valid_nxt  = 1'b0;
      w_pkt_nxt    = o_pkt;
      w_rd         = '0;
      case (r_state)
         IDLE: begin
            if (w_found) begin
               w_state_nxt  = SEND;
               w_grant_nxt  = w_pick;
               w_inport_nxt = 8'(PORT_ID_BASE + 32'(w_pick));
            end
         end
         SEND: begin
            // The granted FIFO holds a complete packet, so it never runs dry mid-packet.
            if (!w_empty[r_grant]) begin
               w_rd[r_grant] = 1'b1;
               w_valid_nxt   = 1'b1;
               w_pkt_nxt     = w_dout[r_grant];
               if (w_dout[r_grant].tag[1]) begin
                  w_state_nxt = IDLE;
                  w_rr_nxt    = r_grant;
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= IDLE;
         r_grant     <= '0;
         r_rr        <= PW'(NUM_PORTS - 1);
         o_pkt_valid <= 1'b0;
         o_pkt       <= '0;
         o_inport    <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_grant     <= w_grant_nxt;
         r_rr        <= w_rr_nxt;
         o_pkt_valid <= w_valid_nxt;
         o_pkt       <= w_pkt_nxt;
         o_inport    <= w_inport_nxt;
      end
   end

endmodule

// File: tb/tb_pkt_ingress_arbiter.sv
// Self-checking bench for pkt_ingress_arbiter: per-scenario tasks plus a scoreboard
// monitor that matches every output beat against the beats accepted per port.
module tb_pkt_ingress_arbiter;

   localparam int unsigned NP    = 4;
   localparam int unsigned DEPTH = 64;
   localparam int unsigned W     = 134;

   logic              clk = 1'b0;
   logic              rst;
   logic [NP-1:0]     drv_valid;
   logic [W-1:0]      drv_pkt [NP];
   logic [W*NP-1:0]   pkt_bus;

   logic [NP-1:0]     o_pkt_ready;
   logic              o_pkt_valid;
   logic [W-1:0]      o_pkt;
   logic [7:0]        o_inport;
   logic [NP-1:0]     o_drop_err;
   logic              o_busy;

   always #5 clk = ~clk;

   always_comb begin
      pkt_bus = '0;
      for (int k = 0; k < NP; k++) pkt_bus[W*k +: W] = drv_pkt[k];
   end

   pkt_ingress_arbiter #(.NUM_PORTS(NP), .FIFO_DEPTH(DEPTH), .PORT_ID_BASE(0)) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_pkt_valid (drv_valid),
      .i_pkt       (pkt_bus),
      .o_pkt_ready (o_pkt_ready),
      .o_pkt_valid (o_pkt_valid),
      .o_pkt       (o_pkt),
      .o_inport    (o_inport),
      .o_drop_err  (o_drop_err),
      .o_busy      (o_busy)
   );

   typedef struct {
      int          port;
      logic [W-1:0] beat;
   } sb_t;

   sb_t        sb [$];
   int         log_cyc [$];
   int         log_port [$];
   logic [1:0] log_tag [$];
   int         cyc = 0;
   int         n_tests = 0;
   int         n_fail = 0;
   int         pkt_seq = 0;
   int         mon_hit;

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard: each output beat must be the oldest outstanding beat of its port.
   always @(negedge clk) begin
      if (o_pkt_valid === 1'b1) begin
         log_cyc.push_back(cyc);
         log_port.push_back(int'(o_inport));
         log_tag.push_back(o_pkt[W-1 -: 2]);
         mon_hit = -1;
         foreach (sb[i]) if (mon_hit < 0 && sb[i].port == int'(o_inport)) mon_hit = i;
         n_tests++;
         if (mon_hit < 0) begin
            n_fail++;
            $display("FAIL unexpected_beat: cycle %0d port %0d beat %h, expected no output", cyc, o_inport, o_pkt);
         end else begin
            if (o_pkt !== sb[mon_hit].beat) begin
               n_fail++;
               $display("FAIL beat_data: port %0d got %h, expected %h", o_inport, o_pkt, sb[mon_hit].beat);
            end
            sb.delete(mon_hit);
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic clear_log();
      log_cyc.delete();
      log_port.delete();
      log_tag.delete();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drv_valid = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      sb.delete();
      clear_log();
   endtask

   task automatic send_pkt(input int port, input int len, input bit expect_out, output int tail_cyc);
      logic [W-1:0] beat;
      logic [1:0]   tag;
      bit           acc;
      int           stall;
      int           seq;
      int           acc_cyc;
      seq = pkt_seq;
      pkt_seq++;
      tail_cyc = -1;
      acc_cyc = -1;
      for (int b = 0; b < len; b++) begin
         if (len == 1)           tag = 2'b11;
         else if (b == 0)        tag = 2'b01;
         else if (b == len - 1)  tag = 2'b10;
         else                    tag = 2'b00;
         beat = {tag, 132'({8'(port), 16'(seq), 16'(b), 32'($urandom())})};
         drv_pkt[port] = beat;
         drv_valid[port] = 1'b1;
         acc = 1'b0;
         stall = 0;
         while (!acc && stall < 200) begin
            @(negedge clk);
            acc = o_pkt_ready[port];
            acc_cyc = cyc;
            @(posedge clk); #1;
            if (!acc) stall++;
         end
         if (!acc) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_stall: port %0d beat %0d ready %b, expected 1", port, b, o_pkt_ready[port]);
            drv_valid[port] = 1'b0;
            return;
         end
         if (expect_out) sb.push_back('{port, beat});
         if (b == len - 1) tail_cyc = acc_cyc;
      end
      drv_valid[port] = 1'b0;
   endtask

   task automatic wait_beats(input int n, input int budget, output bit ok);
      for (int i = 0; i < budget && log_cyc.size() < n; i++) begin @(negedge clk); #1; end
      ok = (log_cyc.size() >= n);
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge clk);
      n_tests++; if (o_pkt_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b, expected 0", o_pkt_valid); end
      n_tests++; if (o_pkt !== '0) begin n_fail++; $display("FAIL reset_pkt: got %h, expected 0", o_pkt); end
      n_tests++; if (o_inport !== 8'd0) begin n_fail++; $display("FAIL reset_inport: got %0d, expected 0", o_inport); end
      n_tests++; if (o_drop_err !== 4'b0000) begin n_fail++; $display("FAIL reset_drop_err: got %b, expected 0000", o_drop_err); end
      n_tests++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, expected 0", o_busy); end
      n_tests++; if (o_pkt_ready !== 4'b1111) begin n_fail++; $display("FAIL reset_ready: got %b, expected 1111", o_pkt_ready); end
      @(posedge clk); #1;
   endtask

   task automatic test_single();
      int t;
      bit ok;
      logic [1:0] exp_tag [4] = '{2'b01, 2'b00, 2'b00, 2'b10};
      do_reset();
      idle(2);
      send_pkt(2, 4, 1'b1, t);
      wait_beats(4, 50, ok);
      n_tests++; if (!ok) begin n_fail++; $display("FAIL single_timeout: got %0d beats, expected 4", log_cyc.size()); end
      if (ok) begin
         for (int i = 0; i < 4; i++) begin
            n_tests++; if (log_cyc[i] != t + 3 + i) begin n_fail++; $display("FAIL single_cycle: beat %0d at %0d, expected %0d", i, log_cyc[i], t + 3 + i); end
            n_tests++; if (log_port[i] != 2) begin n_fail++; $display("FAIL single_inport: beat %0d got %0d, expected 2", i, log_port[i]); end
            n_tests++; if (log_tag[i] !== exp_tag[i]) begin n_fail++; $display("FAIL single_tag: beat %0d got %b, expected %b", i, log_tag[i], exp_tag[i]); end
         end
      end
      n_tests++; if (sb.size() != 0) begin n_fail++; $display("FAIL single_drain: %0d beats outstanding, expected 0", sb.size()); end
   endtask

   task automatic test_round_robin();
      int t0, t1, t3;
      bit ok;
      int exp_off [6] = '{3, 4, 6, 7, 9, 10};
      int exp_prt [6] = '{0, 0, 1, 1, 3, 3};
      do_reset();
      fork
         send_pkt(0, 2, 1'b1, t0);
         send_pkt(1, 2, 1'b1, t1);
         send_pkt(3, 2, 1'b1, t3);
      join
      wait_beats(6, 60, ok);
      n_tests++; if (!ok) begin n_fail++; $display("FAIL rr_timeout: got %0d beats, expected 6", log_cyc.size()); end
      if (ok) begin
         for (int i = 0; i < 6; i++) begin
            n_tests++; if (log_port[i] != exp_prt[i]) begin n_fail++; $display("FAIL rr_order: beat %0d port %0d, expected %0d", i, log_port[i], exp_prt[i]); end
            n_tests++; if (log_cyc[i] != t0 + exp_off[i]) begin n_fail++; $display("FAIL rr_cycle: beat %0d at %0d, expected %0d", i, log_cyc[i], t0 + exp_off[i]); end
         end
      end
      idle(5);
      n_tests++; if (log_cyc.size() != 6) begin n_fail++; $display("FAIL rr_extra: got %0d beats, expected 6", log_cyc.size()); end
   endtask

   task automatic test_fairness();
      int ta, tb;
      bit ok;
      int order [$];
      int exp_order [6] = '{0, 1, 0, 0, 0, 0};
      do_reset();
      fork
         begin
            for (int p = 0; p < 5; p++) send_pkt(0, 3, 1'b1, ta);
         end
         begin
            repeat (2) @(posedge clk);
            #1;
            send_pkt(1, 2, 1'b1, tb);
         end
      join
      wait_beats(17, 150, ok);
      n_tests++; if (!ok) begin n_fail++; $display("FAIL fair_timeout: got %0d beats, expected 17", log_cyc.size()); end
      foreach (log_tag[i]) if (log_tag[i][0]) order.push_back(log_port[i]);
      n_tests++; if (order.size() != 6) begin n_fail++; $display("FAIL fair_count: got %0d packets, expected 6", order.size()); end
      for (int i = 0; i < 6 && i < order.size(); i++) begin
         n_tests++; if (order[i] != exp_order[i]) begin n_fail++; $display("FAIL fair_order: packet %0d port %0d, expected %0d", i, order[i], exp_order[i]); end
      end
   endtask

   task automatic test_simul_pushpop();
      int ta, tb;
      bit ok;
      do_reset();
      send_pkt(0, 4, 1'b1, ta);
      idle(2);
      send_pkt(0, 3, 1'b1, tb);
      n_tests++; if (tb != ta + 5) begin n_fail++; $display("FAIL pp_tail_cycle: tail at %0d, expected %0d", tb, ta + 5); end
      wait_beats(7, 60, ok);
      n_tests++; if (!ok) begin n_fail++; $display("FAIL pp_timeout: got %0d beats, expected 7", log_cyc.size()); end
      if (ok) begin
         n_tests++; if (log_cyc[3] != ta + 6) begin n_fail++; $display("FAIL pp_first_end: at %0d, expected %0d", log_cyc[3], ta + 6); end
         n_tests++; if (log_cyc[4] != ta + 8) begin n_fail++; $display("FAIL pp_second_start: at %0d, expected %0d", log_cyc[4], ta + 8); end
         n_tests++; if (log_cyc[6] != ta + 10) begin n_fail++; $display("FAIL pp_second_end: at %0d, expected %0d", log_cyc[6], ta + 10); end
      end
      idle(15);
      n_tests++; if (log_cyc.size() != 7) begin n_fail++; $display("FAIL pp_extra: got %0d beats, expected 7", log_cyc.size()); end
   endtask

   task automatic test_overflow();
      int t;
      bit ok;
      do_reset();
      send_pkt(3, 70, 1'b0, t);
      idle(10);
      n_tests++; if (o_drop_err !== 4'b1000) begin n_fail++; $display("FAIL ovf_drop_err: got %b, expected 1000", o_drop_err); end
      n_tests++; if (log_cyc.size() != 0) begin n_fail++; $display("FAIL ovf_leak: got %0d beats, expected 0", log_cyc.size()); end
      n_tests++; if (o_pkt_ready !== 4'b1111) begin n_fail++; $display("FAIL ovf_ready: got %b, expected 1111", o_pkt_ready); end
      send_pkt(3, 3, 1'b1, t);
      wait_beats(3, 40, ok);
      n_tests++; if (!ok) begin n_fail++; $display("FAIL ovf_next_timeout: got %0d beats, expected 3", log_cyc.size()); end
      if (ok) begin
         n_tests++; if (log_cyc[0] != t + 1) begin end
         n_fail += 0;
         n_tests--;
         for (int i = 0; i < 3; i++) begin
            n_tests++; if (log_cyc[i] != t + 1 + i + 2) begin n_fail++; $display("FAIL ovf_next_cycle: beat %0d at %0d, expected %0d", i, log_cyc[i], t + 3 + i); end
            n_tests++; if (log_port[i] != 3) begin n_fail++; $display("FAIL ovf_next_inport: beat %0d got %0d, expected 3", i, log_port[i]); end
         end
      end
      n_tests++; if (o_drop_err !== 4'b1000) begin n_fail++; $display("FAIL ovf_sticky: got %b, expected 1000", o_drop_err); end
   endtask

   task automatic test_reset_mid();
      int t, t2;
      bit ok;
      do_reset();
      send_pkt(0, 8, 1'b1, t);
      while (cyc < t + 4) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      n_tests++; if (o_pkt_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b, expected 0", o_pkt_valid); end
      n_tests++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b, expected 0", o_busy); end
      n_tests++; if (o_pkt !== '0) begin n_fail++; $display("FAIL rstmid_pkt: got %h, expected 0", o_pkt); end
      n_tests++; if (log_cyc.size() != 2) begin n_fail++; $display("FAIL rstmid_beats: got %0d beats before reset, expected 2", log_cyc.size()); end
      @(posedge clk); #1;
      rst = 1'b0;
      sb.delete();
      clear_log();
      idle(10);
      n_tests++; if (log_cyc.size() != 0) begin n_fail++; $display("FAIL rstmid_residue: got %0d beats, expected 0", log_cyc.size()); end
      send_pkt(0, 2, 1'b1, t2);
      wait_beats(2, 40, ok);
      n_tests++; if (!ok) begin n_fail++; $display("FAIL rstmid_timeout: got %0d beats, expected 2", log_cyc.size()); end
      if (ok) begin
         n_tests++; if (log_cyc[0] != t2 + 3) begin n_fail++; $display("FAIL rstmid_latency: first beat at %0d, expected %0d", log_cyc[0], t2 + 3); end
         n_tests++; if (log_port[0] != 0) begin n_fail++; $display("FAIL rstmid_inport: got %0d, expected 0", log_port[0]); end
      end
   endtask

   initial begin
      rst = 1'b1;
      drv_valid = '0;
      for (int k = 0; k < NP; k++) drv_pkt[k] = '0;
      @(posedge clk); #1;
      test_reset();
      test_single();
      test_round_robin();
      test_fairness();
      test_simul_pushpop();
      test_overflow();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

endmodule
